// File: rtl/park_pkg.sv
// Shared constants, op encodings and FSM state type for the parking-lot
// occupancy tracker and its space decoder.
package park_pkg;

  localparam int NUM_SPACES = 8;
  localparam int SPACE_W    = 3;
  localparam int CNT_W      = 4;

  localparam logic OP_ENTER = 1'b0;
  localparam logic OP_EXIT  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/park_space_decoder.sv
// Space number to one-hot mask decoder; inverse of the park-space encoder.
// o_valid is high only for space numbers that name a real space.
module park_space_decoder
  import park_pkg::*;
#(
  parameter int N_SPACES = NUM_SPACES,
  parameter int S_W      = SPACE_W
) (
  input  logic [S_W-1:0]      i_space,
  output logic [N_SPACES-1:0] o_mask,
  output logic                o_valid
);

  // Out-of-range numbers match no bit, so validity falls out of the mask.
  for (genvar i = 0; i < N_SPACES; i++) begin : g_bit
    assign o_mask[i] = (i_space == S_W'(i));
  end

  assign o_valid = |o_mask;

endmodule

// File: rtl/park_space_tracker.sv
// Authoritative lot occupancy: applies enter/exit requests to a registered
// one-hot occupancy vector and keeps a registered free-space count.
module park_space_tracker
  import park_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  req_valid,
  input  logic                  req_op,
  input  logic [SPACE_W-1:0]    req_space,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic                  resp_ok,
  output logic [NUM_SPACES-1:0] occupancy,
  output logic [CNT_W-1:0]      free_count,
  output logic                  full,
  output logic                  empty
);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_op;
  logic [SPACE_W-1:0]    r_space;
  logic                  r_en;
  logic                  r_ok;
  logic [NUM_SPACES-1:0] r_occupancy;
  logic [CNT_W-1:0]      r_free_count;
  logic                  r_full;
  logic                  r_empty;

  logic [NUM_SPACES-1:0] w_mask;
  logic                  w_in_range;
  logic                  w_hit;
  logic                  w_ok;
  logic [CNT_W-1:0]      w_next_count;

  park_space_decoder u_decoder (
    .i_space (r_space),
    .o_mask  (w_mask),
    .o_valid (w_in_range)
  );

  assign w_hit        = |(r_occupancy & w_mask);
  assign w_ok         = r_en & w_in_range & ((r_op == OP_ENTER) ? ~w_hit : w_hit);
  assign w_next_count = (r_op == OP_ENTER) ? r_free_count - CNT_W'(1)
                                           : r_free_count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_ok      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next_state = S_APPLY;
      end
      S_APPLY: w_next_state = S_RESP;
      S_RESP: begin
        resp_valid   = 1'b1;
        resp_ok      = r_ok;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op         <= OP_ENTER;
      r_space      <= '0;
      r_en         <= 1'b0;
      r_ok         <= 1'b0;
      r_occupancy  <= '0;
      r_free_count <= CNT_W'(NUM_SPACES);
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_space <= req_space;
            r_en    <= enable;
          end else if (clear) begin
            r_occupancy  <= '0;
            r_free_count <= CNT_W'(NUM_SPACES);
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
          end
        end
        S_APPLY: begin
          r_ok <= w_ok;
          // A rejected request leaves count and flags untouched, so the
          // count can never wrap.
          if (w_ok) begin
            r_occupancy  <= (r_op == OP_ENTER) ? (r_occupancy | w_mask)
                                               : (r_occupancy & ~w_mask);
            r_free_count <= w_next_count;
            r_full       <= (w_next_count == '0);
            r_empty      <= (w_next_count == CNT_W'(NUM_SPACES));
          end
        end
        default: ;
      endcase
    end
  end

  assign occupancy  = r_occupancy;
  assign free_count = r_free_count;
  assign full       = r_full;
  assign empty      = r_empty;

  a_count_matches: assert property (@(posedge clk) disable iff (reset)
    int'(r_free_count) == NUM_SPACES - $countones(r_occupancy));

endmodule

// File: doc/park_space_tracker.md
Name: park_space_tracker

Overview:
- Sequential counterpart to the park-space number encoder. The encoder turns an 8-bit capacity vector into a 3-bit space number; this block takes a 3-bit space number plus an enter/exit command and decodes it into a one-hot update of a registered occupancy vector.
- Holds the authoritative occupancy state of the lot and the free-space count.
- The gate controller drives requests through a valid/ready/response handshake.
- The occupancy output feeds the encoder's capacity input for next-free-space lookup.

Parameters:
- NUM_SPACES, 8, number of parking spaces (bits in occupancy vector).
- SPACE_W, 3, width of space number; NUM_SPACES <= 2**SPACE_W.
- CNT_W, 4, width of free count; holds 0..NUM_SPACES.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- enable  in  1  when 0, accepted requests complete with error and do not change occupancy.
- clear  in  1  synchronous lot clear; all spaces free. Only honoured in IDLE.
- req_valid  in  1  request present.
- req_op  in  1  0 = enter (occupy), 1 = exit (release).
- req_space  in  SPACE_W  target space number.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_ok  out  1  qualified by resp_valid; 1 = applied, 0 = rejected.
- occupancy  out  NUM_SPACES  bit i = 1 when space i is taken.
- free_count  out  CNT_W  number of zero bits in occupancy.
- full  out  1  free_count == 0.
- empty  out  1  free_count == NUM_SPACES.

Behaviour:
- Reset values:
  - state IDLE, req_ready = 1, resp_valid = 0, resp_ok = 0.
  - occupancy = 0, free_count = NUM_SPACES, full = 0, empty = 1.
- FSM states are IDLE, APPLY and RESP.
- IDLE:
  - req_ready = 1.
  - If req_valid, latch op, space and enable, then go to APPLY.
  - Otherwise, if clear, zero occupancy, set free_count = NUM_SPACES and stay in IDLE.
  - req_valid takes priority over clear when both are high in the same cycle.
- APPLY:
  - req_ready = 0.
  - Decode the latched space to one-hot mask m.
  - ok = latched_enable & (space < NUM_SPACES) & (op == enter ? ~|(occupancy & m) : |(occupancy & m)).
  - If ok: enter sets occupancy |= m and decrements free_count; exit clears occupancy &= ~m and increments free_count.
  - Register ok, then go to RESP.
- RESP:
  - resp_valid = 1 and resp_ok = registered ok for exactly one cycle.
  - Updated occupancy and free_count are already visible this cycle.
  - Return to IDLE.
- Latency:
  - Accept at edge N; occupancy updates at edge N+1; resp_valid is high during cycle N+2.
  - Throughput is one request per 3 cycles.
- Boundary conditions:
  - free_count never under- or overflows. A rejected enter when full, or exit when empty, leaves the count unchanged.
  - Entering an occupied space or exiting a free space gives resp_ok = 0 and no state change.
  - req_space >= NUM_SPACES is rejected.
  - req_* inputs are ignored while req_ready = 0.
  - clear is ignored outside IDLE and has no latching effect.
  - reset in any state returns to the reset values on the next edge. A pending response is dropped with no resp_valid.
- Width rules: free_count and full/empty are maintained as registers updated in APPLY, not as a popcount. An assertion checks free_count == NUM_SPACES - popcount(occupancy).

Decomposition:
- Shared package park_pkg:
  - constants NUM_SPACES, SPACE_W, CNT_W.
  - op encodings OP_ENTER = 1'b0, OP_EXIT = 1'b1.
  - FSM state encodings S_IDLE, S_APPLY, S_RESP.
- One natural sub-module: park_space_decoder.
  - Combinational SPACE_W to NUM_SPACES one-hot decoder with a valid output for in-range space numbers.
  - It is the inverse of the existing encoder and reusable by the display path.

Test Plan:
- Reset then idle:
  - occupancy = 8'h00, free_count = 8, empty = 1, full = 0, req_ready = 1, resp_valid = 0.
- enable = 1, enter space 3:
  - resp_valid pulses 2 cycles after accept with resp_ok = 1.
  - occupancy = 8'h08, free_count = 7.
- enable = 1, enter space 3 again:
  - resp_ok = 0, occupancy stays 8'h08.
  - A following exit of space 5 also gives resp_ok = 0.
  - Exit of space 3 gives resp_ok = 1, occupancy = 8'h00, free_count = 8.
- enable = 1, enter spaces 0 through 7 in sequence:
  - After the last response, occupancy = 8'hFF, free_count = 0, full = 1.
  - A 9th enter of any space gives resp_ok = 0 and free_count stays 0.
- enable = 0, enter space 6:
  - resp_ok = 0, occupancy unchanged.
  - clear asserted in IDLE with occupancy = 8'hFF gives occupancy = 8'h00 and free_count = 8 the next cycle.
  - clear asserted during APPLY is ignored.
- enter space 2 accepted, then reset asserted in the APPLY cycle:
  - No resp_valid is seen.
  - occupancy = 8'h00, free_count = 8, req_ready = 1 after the reset edge.
